// File: rtl/derr_store_pkg.sv
// Shared definitions for the chroma DC diffusion-error store: lane offsets,
// table depth default, FSM encoding and the per-channel error split.
package derr_store_pkg;

    localparam int DEPTH_DEF = 1024;
    localparam int ADDR_W    = 10;
    localparam int DERR_W    = 48;
    localparam int DATA_W    = 32;

    // Byte-lane offsets of the packed derr input
    localparam int U_E1_LSB = 0;
    localparam int U_E2_LSB = 8;
    localparam int U_E3_LSB = 16;
    localparam int V_E1_LSB = 24;
    localparam int V_E2_LSB = 32;
    localparam int V_E3_LSB = 40;

    // Byte-lane offsets shared by top_derr and left_derr
    localparam int U0_LSB = 0;
    localparam int U1_LSB = 8;
    localparam int V0_LSB = 16;
    localparam int V1_LSB = 24;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] left1;
        logic [7:0] left0;
        logic [7:0] top1;
        logic [7:0] top0;
    } chan_res_t;

    // Splits e3 into 3/4 for the left neighbour (floor) and the remainder for the top
    function automatic chan_res_t calc_chan(input logic [7:0] e1,
                                            input logic [7:0] e2,
                                            input logic [7:0] e3);
        chan_res_t          res;
        logic signed [9:0]  e3x;
        logic signed [9:0]  prod;
        logic signed [9:0]  l1;
        e3x       = {{2{e3[7]}}, e3};
        prod      = (e3x <<< 1) + e3x;
        l1        = prod >>> 2;
        res.left0 = e1;
        res.left1 = l1[7:0];
        res.top0  = e2;
        res.top1  = e3 - l1[7:0];
        return res;
    endfunction

endpackage

// File: rtl/derr_store_ram.sv
// Single-clock DEPTH x DW table: one write port and one registered,
// read-first read port with synchronous zeroing of the read register.
module derr_ram
    import derr_store_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 10,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rzero,
    input  logic          rclr,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Table write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register samples the pre-write contents, so same-address reads see old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {DW{1'b0}};
        end else if (rclr) begin
            rdata_q <= {DW{1'b0}};
        end else if (re) begin
            if (rzero) begin
                rdata_q <= {DW{1'b0}};
            end else begin
                rdata_q <= mem_q[raddr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/derr_store.sv
// Chroma DC diffusion-error store: splits each macroblock's errors into left
// and top contributions, keeps the top ones per column, and clears per frame.
module derr_store
    import derr_store_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_x,
    input  logic [DERR_W-1:0] derr,
    input  logic              top_derr_en,
    input  logic [ADDR_W-1:0] top_derr_addr,
    output logic [DATA_W-1:0] top_derr,
    output logic [DATA_W-1:0] left_derr,
    output logic              wr_done,
    output logic              busy,
    output logic              wr_drop
);

    localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                sweep_we_s;

    logic                s1_valid_q;
    logic [ADDR_W-1:0]   s1_x_q;
    logic [DERR_W-1:0]   s1_derr_q;
    logic [DATA_W-1:0]   left_q;
    logic                wr_done_q;
    logic                wr_drop_q;

    logic                busy_s;
    logic                commit_s;
    logic                rd_zero_s;
    chan_res_t           u_res_s, v_res_s;
    logic [DATA_W-1:0]   entry_s, left_s;
    logic                ram_we_s;
    logic [AW-1:0]       ram_waddr_s;
    logic [DATA_W-1:0]   ram_wdata_s;

    assign busy_s    = (state_q == ST_CLEAR);
    assign commit_s  = s1_valid_q & ({1'b0, s1_x_q} < DEPTH_L);
    assign rd_zero_s = busy_s | ({1'b0, top_derr_addr} >= DEPTH_L);

    // Sweep state and address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep sequencing; a pipelined commit borrows the write port and stalls the sweep
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (frame_start) begin
                    cnt_d = {AW{1'b0}};
                end else if (commit_s) begin
                    cnt_d = cnt_q;
                end else begin
                    sweep_we_s = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        cnt_d   = {AW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // Capture stage of the write pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= {ADDR_W{1'b0}};
            s1_derr_q  <= {DERR_W{1'b0}};
        end else begin
            s1_valid_q <= wr_en & ~busy_s;
            if (wr_en & ~busy_s) begin
                s1_x_q    <= wr_x;
                s1_derr_q <= derr;
            end else begin
                s1_x_q    <= s1_x_q;
                s1_derr_q <= s1_derr_q;
            end
        end
    end

    // Error split and packing of the table entry and left outputs
    always_comb begin
        u_res_s = calc_chan(s1_derr_q[U_E1_LSB +: 8], s1_derr_q[U_E2_LSB +: 8],
                            s1_derr_q[U_E3_LSB +: 8]);
        v_res_s = calc_chan(s1_derr_q[V_E1_LSB +: 8], s1_derr_q[V_E2_LSB +: 8],
                            s1_derr_q[V_E3_LSB +: 8]);
        entry_s = {DATA_W{1'b0}};
        left_s  = {DATA_W{1'b0}};
        entry_s[U0_LSB +: 8] = u_res_s.top0;
        entry_s[U1_LSB +: 8] = u_res_s.top1;
        entry_s[V0_LSB +: 8] = v_res_s.top0;
        entry_s[V1_LSB +: 8] = v_res_s.top1;
        left_s[U0_LSB +: 8]  = u_res_s.left0;
        left_s[U1_LSB +: 8]  = u_res_s.left1;
        left_s[V0_LSB +: 8]  = v_res_s.left0;
        left_s[V1_LSB +: 8]  = v_res_s.left1;
    end

    // Table write-port arbitration
    always_comb begin
        ram_we_s    = commit_s | sweep_we_s;
        ram_waddr_s = cnt_q;
        ram_wdata_s = {DATA_W{1'b0}};
        if (commit_s) begin
            ram_waddr_s = s1_x_q[AW-1:0];
            ram_wdata_s = entry_s;
        end else begin
            ram_waddr_s = cnt_q;
            ram_wdata_s = {DATA_W{1'b0}};
        end
    end

    // Commit stage outputs; starting a sweep zeroes the left errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q    <= {DATA_W{1'b0}};
            wr_done_q <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            if (frame_start) begin
                left_q <= {DATA_W{1'b0}};
            end else if (commit_s) begin
                left_q <= left_s;
            end else begin
                left_q <= left_q;
            end
            wr_done_q <= commit_s;
            wr_drop_q <= wr_en & busy_s;
        end
    end

    derr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (top_derr_en),
        .rzero (rd_zero_s),
        .rclr  (frame_start),
        .raddr (top_derr_addr[AW-1:0]),
        .rdata (top_derr)
    );

    assign left_derr = left_q;
    assign wr_done   = wr_done_q;
    assign busy      = busy_s;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_derr_store.sv
// Directed self-checking bench for derr_store (table depth reduced to 1000
// so out-of-range columns are reachable).
module tb_derr_store;

    localparam int TB_DEPTH = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_x = 10'd0;
    logic [47:0] derr = 48'd0;
    logic        top_derr_en = 1'b0;
    logic [9:0]  top_derr_addr = 10'd0;
    logic [31:0] top_derr;
    logic [31:0] left_derr;
    logic        wr_done;
    logic        busy;
    logic        wr_drop;

    int n_total = 0;
    int n_pass  = 0;

    derr_store #(.DEPTH(TB_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .wr_en         (wr_en),
        .wr_x          (wr_x),
        .derr          (derr),
        .top_derr_en   (top_derr_en),
        .top_derr_addr (top_derr_addr),
        .top_derr      (top_derr),
        .left_derr     (left_derr),
        .wr_done       (wr_done),
        .busy          (busy),
        .wr_drop       (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a write and advance to the cycle where wr_done should be high
    task automatic do_write(input logic [9:0] x, input logic [47:0] d);
        wr_en = 1'b1; wr_x = x; derr = d;
        tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [9:0] a);
        top_derr_en = 1'b1; top_derr_addr = a;
        tick();
        top_derr_en = 1'b0;
    endtask

    // Back-to-back vector i: u_e3 = 4i, v_e3 = -4i so the 3/4 split is exact
    function automatic logic [47:0] b2b_derr(input int i);
        logic [7:0] n;
        n = 8'(i);
        return {8'd0 - (n << 2), 8'h40 + n, 8'h30 + n, n << 2, 8'h20 + n, 8'h10 + n};
    endfunction

    function automatic logic [31:0] b2b_top(input int i);
        logic [7:0] n;
        n = 8'(i);
        return {8'd0 - n, 8'h40 + n, n, 8'h20 + n};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_total++;
        if ({top_derr, left_derr, wr_done, busy, wr_drop} !== 67'd0)
            $display("FAIL reset_outputs got top=%h left=%h done=%b busy=%b drop=%b want all 0",
                     top_derr, left_derr, wr_done, busy, wr_drop);
        else n_pass++;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_write();
        wr_en = 1'b1; wr_x = 10'd3; derr = 48'hF906FC07FD05;
        tick();
        wr_en = 1'b0;
        n_total++;
        if (wr_done !== 1'b0) $display("FAIL basic_done_n1 got %b want 0", wr_done);
        else n_pass++;
        tick();
        n_total++;
        if (wr_done !== 1'b1) $display("FAIL basic_done_n2 got %b want 1", wr_done);
        else n_pass++;
        n_total++;
        if (left_derr !== 32'hFAFC0505) $display("FAIL basic_left got %h want FAFC0505", left_derr);
        else n_pass++;
        tick();
        n_total++;
        if (wr_done !== 1'b0) $display("FAIL basic_done_n3 got %b want 0", wr_done);
        else n_pass++;
        do_read(10'd3);
        n_total++;
        if (top_derr !== 32'hFF0602FD) $display("FAIL basic_top got %h want FF0602FD", top_derr);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (top_derr !== 32'hFF0602FD) $display("FAIL basic_top_hold got %h want FF0602FD", top_derr);
        else n_pass++;
    endtask

    task automatic test_e3_bounds();
        do_write(10'd10, 48'h010000800000);
        n_total++;
        if (left_derr !== 32'h0000A000) $display("FAIL e3_neg_left got %h want 0000A000", left_derr);
        else n_pass++;
        do_read(10'd10);
        n_total++;
        if (top_derr !== 32'h0100E000) $display("FAIL e3_neg_top got %h want 0100E000", top_derr);
        else n_pass++;
        do_write(10'd11, 48'hFD00007F0000);
        n_total++;
        if (left_derr !== 32'hFD005F00) $display("FAIL e3_pos_left got %h want FD005F00", left_derr);
        else n_pass++;
        do_read(10'd11);
        n_total++;
        if (top_derr !== 32'h00002000) $display("FAIL e3_pos_top got %h want 00002000", top_derr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int bad_timing;
        done_cnt   = 0;
        bad_timing = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_x = 10'(i); derr = b2b_derr(i);
            tick();
            if (wr_done === 1'b1) done_cnt++;
            if (wr_done !== (i >= 1)) bad_timing++;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_done === 1'b1) done_cnt++;
            if (wr_done !== (i == 0)) bad_timing++;
        end
        n_total++;
        if (done_cnt != 8) $display("FAIL b2b_done_count got %0d want 8", done_cnt);
        else n_pass++;
        n_total++;
        if (bad_timing != 0) $display("FAIL b2b_done_timing got %0d misplaced cycles want 0", bad_timing);
        else n_pass++;
        n_total++;
        if (left_derr !== 32'hEB371517) $display("FAIL b2b_left_last got %h want EB371517", left_derr);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            top_derr_en = 1'b1; top_derr_addr = 10'(i);
            tick();
            n_total++;
            if (top_derr !== b2b_top(i)) $display("FAIL b2b_read_%0d got %h want %h", i, top_derr, b2b_top(i));
            else n_pass++;
        end
        top_derr_en = 1'b0;
        tick();
    endtask

    task automatic test_read_first();
        wr_en = 1'b1; wr_x = 10'd5; derr = 48'hF906FC07FD05;
        tick();
        wr_en = 1'b0;
        top_derr_en = 1'b1; top_derr_addr = 10'd5;
        tick();
        n_total++;
        if (top_derr !== b2b_top(5)) $display("FAIL rf_old got %h want %h", top_derr, b2b_top(5));
        else n_pass++;
        tick();
        top_derr_en = 1'b0;
        n_total++;
        if (top_derr !== 32'hFF0602FD) $display("FAIL rf_new got %h want FF0602FD", top_derr);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        do_write(10'd999, 48'h010000800000);
        do_write(10'd1000, 48'hF906FC07FD05);
        do_read(10'd999);
        n_total++;
        if (top_derr !== 32'h0100E000) $display("FAIL oor_last_entry got %h want 0100E000", top_derr);
        else n_pass++;
        do_read(10'd1000);
        n_total++;
        if (top_derr !== 32'd0) $display("FAIL oor_read_1000 got %h want 0", top_derr);
        else n_pass++;
        do_read(10'd999);
        do_read(10'd1023);
        n_total++;
        if (top_derr !== 32'd0) $display("FAIL oor_read_1023 got %h want 0", top_derr);
        else n_pass++;
    endtask

    // Sweep with a dropped write at sweep cycle 10 and a read at cycle 20
    task automatic test_clear();
        int k, busy_cycles, drop_cnt, drop_k, done_cnt, nz;
        k = 0; busy_cycles = 0; drop_cnt = 0; drop_k = -1; done_cnt = 0; nz = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (busy === 1'b1 && k < 3000) begin
            busy_cycles++;
            wr_en = (k == 10); wr_x = 10'd2; derr = 48'hF906FC07FD05;
            top_derr_en = (k == 20); top_derr_addr = 10'd3;
            tick();
            if (wr_drop === 1'b1) begin drop_cnt++; drop_k = k; end
            if (wr_done === 1'b1) done_cnt++;
            if (k == 20) begin
                n_total++;
                if (top_derr !== 32'd0) $display("FAIL clr_read_busy got %h want 0", top_derr);
                else n_pass++;
                n_total++;
                if (left_derr !== 32'd0) $display("FAIL clr_left got %h want 0", left_derr);
                else n_pass++;
            end
            k++;
        end
        wr_en = 1'b0; top_derr_en = 1'b0;
        n_total++;
        if (busy_cycles != TB_DEPTH) $display("FAIL clr_busy_len got %0d want %0d", busy_cycles, TB_DEPTH);
        else n_pass++;
        n_total++;
        if (drop_cnt != 1 || drop_k != 10)
            $display("FAIL clr_drop got %0d pulses at k=%0d want 1 at k=10", drop_cnt, drop_k);
        else n_pass++;
        n_total++;
        if (done_cnt != 0) $display("FAIL clr_no_done got %0d want 0", done_cnt);
        else n_pass++;
        for (int a = 0; a < TB_DEPTH; a++) begin
            top_derr_en = 1'b1; top_derr_addr = 10'(a);
            tick();
            if (top_derr !== 32'd0) nz++;
        end
        top_derr_en = 1'b0;
        n_total++;
        if (nz != 0) $display("FAIL clr_all_zero got %0d nonzero entries want 0", nz);
        else n_pass++;
    endtask

    task automatic test_restart();
        int k, busy_cycles;
        k = 0; busy_cycles = 0;
        frame_start = 1'b1;
        tick();
        while (busy === 1'b1 && k < 3000) begin
            busy_cycles++;
            frame_start = (k == 5);
            tick();
            k++;
        end
        frame_start = 1'b0;
        n_total++;
        if (busy_cycles != TB_DEPTH + 6)
            $display("FAIL restart_busy_len got %0d want %0d", busy_cycles, TB_DEPTH + 6);
        else n_pass++;
    endtask

    task automatic test_pending_write();
        int k;
        k = 0;
        wr_en = 1'b1; wr_x = 10'd4; derr = 48'hF906FC07FD05;
        tick();
        wr_en = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_total++;
        if ({wr_done, busy, left_derr} !== {1'b1, 1'b1, 32'd0})
            $display("FAIL pend_commit got done=%b busy=%b left=%h want 1 1 0", wr_done, busy, left_derr);
        else n_pass++;
        while (busy === 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        n_total++;
        if (k != TB_DEPTH) $display("FAIL pend_busy_len got %0d want %0d", k, TB_DEPTH);
        else n_pass++;
        do_read(10'd4);
        n_total++;
        if (top_derr !== 32'd0) $display("FAIL pend_overwritten got %h want 0", top_derr);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        int done_cnt;
        done_cnt = 0;
        do_write(10'd6, 48'hF906FC07FD05);
        do_read(10'd6);
        wr_en = 1'b1; wr_x = 10'd7; derr = 48'h010000800000;
        tick();
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({top_derr, left_derr, wr_done, busy, wr_drop} !== 67'd0)
            $display("FAIL rst_mid_write got top=%h left=%h done=%b busy=%b drop=%b want all 0",
                     top_derr, left_derr, wr_done, busy, wr_drop);
        else n_pass++;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_done === 1'b1) done_cnt++;
        end
        n_total++;
        if (done_cnt != 0) $display("FAIL rst_no_done got %0d want 0", done_cnt);
        else n_pass++;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, top_derr, left_derr, wr_done, wr_drop} !== 67'd0)
            $display("FAIL rst_mid_sweep got busy=%b top=%h left=%h want 0", busy, top_derr, left_derr);
        else n_pass++;
        #1 rst = 1'b0;
        tick(); tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_sweep_aborted got busy=%b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_e3_bounds();
        test_back_to_back();
        test_read_first();
        test_out_of_range();
        test_clear();
        test_restart();
        test_pending_write();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
